pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Program-counter and hardware return-stack stage that sits directly upstream of the control unit. Each cycle it presents the fetch address `PC` to instruction memory. The fetched opcode is decoded combinationally into `PCpp`/`JMP`/`ret`/`Call`, and this block consumes those signals to compute the next `PC`. It also owns the call/return address stack and reports stack faults and halt.

## Interface
Parameters:
- `AW`, 16, width of `PC`, the jump target and the stack entries.
- `DEPTH`, 8, number of return-stack entries (power of two, ≥2).
- `RESET_PC`, 0, value loaded into `PC` on reset.

Ports:
- `CLK`  in  1  rising-edge clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `STALL`  in  1  freezes all state this cycle (bus wait).
- `PCpp`  in  1  advance to `PC+1`.
- `JMP`  in  1  load `TARGET` (asserted together with `ret` on returns).
- `ret`  in  1  pop the stack into `PC`.
- `Call`  in  1  push `PC+1` and load `TARGET`.
- `TARGET`  in  AW  jump/call destination taken from the current instruction.
- `PC`  out  AW  registered fetch address.
- `SP`  out  $clog2(DEPTH)+1  number of valid stack entries (0..DEPTH).
- `STK_OVF`  out  1  sticky; a `Call` occurred with the stack full.
- `STK_UNF`  out  1  sticky; a `ret` occurred with the stack empty.
- `HALT`  out  1  registered; the previous non-stalled cycle had no control asserted.

## Operation
- State: `PC` register, `DEPTH`×`AW` stack array, `SP` counter, two sticky flags, `HALT` register.
- Next-state priority on each non-stalled edge: `ret` > `Call` > `JMP` > `PCpp` > hold.
  - **ret**: `JMP` is ignored.
    - If `SP>0`: `PC <= stack[SP-1]`, `SP <= SP-1`.
    - If `SP==0`: `PC <= RESET_PC`, `STK_UNF <= 1`, `SP` stays 0.
  - **Call**: `PCpp` is ignored; `Call` arrives with `PCpp=1` from the decoder.
    - If `SP<DEPTH`: `stack[SP] <= PC+1`, `SP <= SP+1`, `PC <= TARGET`.
    - If `SP==DEPTH`: the push is discarded, `PC <= TARGET` still, `STK_OVF <= 1`.
  - **JMP only**: `PC <= TARGET`.
  - **PCpp only**: `PC <= PC+1`.
  - **None asserted** (opcode 0): `PC` holds and `HALT <= 1`. Any later asserted control clears `HALT` on that edge.
- Arithmetic: `PC+1` is modulo 2^AW, so `PC` wraps from all-ones to 0. The pushed return address wraps the same way.
- `STALL=1`: nothing changes. `PC`, `SP`, the stack, the flags and `HALT` all hold, and control inputs are ignored.
- Sticky flags clear only on `RST`.
- Stack contents are not reset. Only entries below `SP` are meaningful.

## Timing
- Reset values after an edge with `RST=1`: `PC=RESET_PC`, `SP=0`, `STK_OVF=0`, `STK_UNF=0`, `HALT=0`.
  - `RST` overrides `STALL` and every control input.
  - Reset mid-call sequence discards all stack entries.
- Control inputs are combinational from the instruction at the current `PC`. They are sampled on the rising edge, and the new `PC` is visible one cycle later.
- One instruction per non-stalled cycle. There is no internal pipeline and no bubbles.
- The `Call` → `ret` round trip needs no forwarding: a `ret` in the cycle after a `Call` pops the just-pushed value.
- All outputs are registered, so no combinational path runs from inputs to outputs.

## Test plan
- **Reset and increment**: assert `RST`, then `PCpp=1` for 5 cycles. Required: `PC` = 0,1,2,3,4,5; `SP=0`; `HALT=0`.
- **Call/return nesting**: from `PC=0x0010`, `Call` with `TARGET=0x0100`, then `Call` with `TARGET=0x0200` at `0x0100`, then `ret`, `ret`.
  - `PC` = 0x0100, 0x0200, 0x0101, 0x0011.
  - `SP` = 1, 2, 1, 0.
- **Stack faults** (`DEPTH=8`):
  - 9 consecutive `Call`s: `SP` saturates at 8, the 9th still jumps, `STK_OVF=1`.
  - After reset, a `ret` with `SP=0`: `PC=RESET_PC`, `STK_UNF=1`, `SP=0`.
- **Priority and wrap**:
  - `ret`+`JMP` with `SP=1`, stack top 0x0042, `TARGET=0x0999`: `PC=0x0042`.
  - `PC=0xFFFF` with `PCpp`: `PC=0x0000`.
  - `Call` at `0xFFFF` pushes `0x0000`.
- **Stall and halt**:
  - `STALL=1` for 3 cycles with `Call` asserted: `PC`, `SP` and flags unchanged.
  - All controls 0: `PC` holds and `HALT=1` next cycle; `JMP` then clears it.
- **Reset mid-operation**: push 3 entries, assert `RST` together with `STALL` and `ret`. Required: `PC=RESET_PC`, `SP=0`, flags 0.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter plus hardware call/return stack.
// Each non-stalled edge consumes the decoded control bits (ret > Call >
// JMP > PCpp > hold) and computes the next fetch address. The return
// stack holds PC+1 of every Call. Underflow and overflow are recorded in
// sticky flags, and a cycle with no control asserted raises HALT.
// All outputs come straight from registers.

module pc_stack_unit #(
  parameter int              AW       = 16,
  parameter int              DEPTH    = 8,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     STALL,
  input  logic                     PCpp,
  input  logic                     JMP,
  input  logic                     ret,
  input  logic                     Call,
  input  logic [AW-1:0]            TARGET,
  output logic [AW-1:0]            PC,
  output logic [$clog2(DEPTH):0]   SP,
  output logic                     STK_OVF,
  output logic                     STK_UNF,
  output logic                     HALT
);

  // Pointer width that indexes the stack array. SP carries one extra bit
  // so that it can represent the full count 0..DEPTH.
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW:0] SP_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] SP_ONE  = (PW+1)'(1);

  // Resolved operation for this cycle after priority has been applied.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_JMP,
    OP_CALL,
    OP_RET
  } op_e;

  op_e            op;

  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  stack_top;
  logic [PW-1:0]  push_idx;
  logic [PW-1:0]  pop_idx;
  logic           stk_full;
  logic           stk_empty;

  logic [AW-1:0]  pc_next;
  logic [PW:0]    sp_next;
  logic           ovf_next;
  logic           unf_next;
  logic           halt_next;
  logic           push;

  logic [AW-1:0]  stack_mem [DEPTH];

  // PC+1 wraps modulo 2^AW. The same value is pushed as the return address.
  assign pc_inc    = PC + AW'(1);

  // The next free slot is SP. The top valid entry is SP-1. Both are taken
  // modulo DEPTH. The out-of-range values (SP==DEPTH for the push, SP==0
  // for the pop) are never used because the full/empty checks block them.
  assign push_idx  = SP[PW-1:0];
  assign pop_idx   = PW'(SP - SP_ONE);
  assign stack_top = stack_mem[pop_idx];

  assign stk_full  = (SP == SP_FULL);
  assign stk_empty = (SP == '0);

  // Priority decode of the control bits into a single operation.
  // NOTE: every signal assigned in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op = OP_HOLD;
    if (ret) begin
      op = OP_RET;
    end else if (Call) begin
      op = OP_CALL;
    end else if (JMP) begin
      op = OP_JMP;
    end else if (PCpp) begin
      op = OP_INC;
    end
  end

  // Next-state computation for PC, SP, the sticky flags and the push strobe.
  always_comb begin
    pc_next   = PC;
    sp_next   = SP;
    ovf_next  = STK_OVF;
    unf_next  = STK_UNF;
    push      = 1'b0;
    halt_next = (op == OP_HOLD);

    case (op)
      OP_RET: begin
        if (stk_empty) begin
          // Returning with nothing on the stack restarts the program and
          // records the fault. SP stays at zero.
          pc_next  = RESET_PC;
          unf_next = 1'b1;
        end else begin
          pc_next = stack_top;
          sp_next = SP - SP_ONE;
        end
      end
      OP_CALL: begin
        // The jump is always taken. Only the push is dropped when full.
        pc_next = TARGET;
        if (stk_full) begin
          ovf_next = 1'b1;
        end else begin
          push    = 1'b1;
          sp_next = SP + SP_ONE;
        end
      end
      OP_JMP: begin
        pc_next = TARGET;
      end
      OP_INC: begin
        pc_next = pc_inc;
      end
      default: begin
        // OP_HOLD: PC holds. halt_next was already set above.
      end
    endcase
  end

  // Architectural registers. Reset overrides the stall and every control bit.
  // NOTE: sequential state uses non-blocking assignments, so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC      <= RESET_PC;
      SP      <= '0;
      STK_OVF <= 1'b0;
      STK_UNF <= 1'b0;
      HALT    <= 1'b0;
    end else if (!STALL) begin
      PC      <= pc_next;
      SP      <= sp_next;
      STK_OVF <= ovf_next;
      STK_UNF <= unf_next;
      HALT    <= halt_next;
    end
  end

  // Return-stack storage. Writes are blocked while reset or stall is active.
  // NOTE: the array itself is not reset. Clearing SP is enough, because only
  // entries below SP are ever read. This keeps the array mappable to RAM.
  always_ff @(posedge CLK) begin
    if (!RST && !STALL && push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Testbench for pc_stack_unit. It applies a table of directed vectors with
// constant expected outputs, then hand-written multi-cycle sequences
// (overflow with LIFO unwind, address wrap, reset in mid-operation), then
// randomized traffic compared against a queue-based reference model.

module tb_pc_stack_unit;

  localparam int          AW       = 16;
  localparam int          DEPTH    = 8;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, stall, pcpp, jmp, ret, call;
  logic [15:0] target;
  logic [15:0] pc;
  logic [3:0]  sp;
  logic        stk_ovf, stk_unf, halt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(clk), .RST(rst), .STALL(stall), .PCpp(pcpp), .JMP(jmp),
    .ret(ret), .Call(call), .TARGET(target), .PC(pc), .SP(sp),
    .STK_OVF(stk_ovf), .STK_UNF(stk_unf), .HALT(halt)
  );

  // Reference model: the return stack is a queue whose size is SP.
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_ovf, m_unf, m_halt;

  task automatic model_step(input logic r, s, pp, j, rt, c,
                            input logic [15:0] t);
    logic [15:0] nxt;
    nxt = m_pc + 16'd1;
    if (r) begin
      m_pc = RESET_PC;
      m_stack.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_halt = 1'b0;
    end else if (!s) begin
      m_halt = !(pp || j || rt || c);
      if (rt) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = RESET_PC; m_unf = 1'b1; end
      end else if (c) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(nxt);
        else m_ovf = 1'b1;
        m_pc = t;
      end else if (j) begin
        m_pc = t;
      end else if (pp) begin
        m_pc = nxt;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] e_pc,
                               input logic [3:0] e_sp,
                               input logic e_ovf, e_unf, e_halt);
    check({tag, ".pc"},   32'(pc),      32'(e_pc));
    check({tag, ".sp"},   32'(sp),      32'(e_sp));
    check({tag, ".ovf"},  32'(stk_ovf), 32'(e_ovf));
    check({tag, ".unf"},  32'(stk_unf), 32'(e_unf));
    check({tag, ".halt"}, 32'(halt),    32'(e_halt));
  endtask

  // Drive inputs, take one edge, sample 1 ns later and advance the model.
  task automatic step(input logic r, s, pp, j, rt, c, input logic [15:0] t);
    rst = r; stall = s; pcpp = pp; jmp = j; ret = rt; call = c; target = t;
    @(posedge clk);
    #1;
    model_step(r, s, pp, j, rt, c, t);
  endtask

  typedef struct {
    logic        rst, stall, pcpp, jmp, ret, call;
    logic [15:0] target;
    logic [15:0] pc;
    logic [3:0]  sp;
    logic        ovf, unf, halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, s, pp, j, rt, c, logic [15:0] t,
                              logic [15:0] e_pc, logic [3:0] e_sp,
                              logic e_ovf, e_unf, e_halt);
    vec_t v;
    v.rst = r; v.stall = s; v.pcpp = pp; v.jmp = j; v.ret = rt; v.call = c;
    v.target = t; v.pc = e_pc; v.sp = e_sp;
    v.ovf = e_ovf; v.unf = e_unf; v.halt = e_halt;
    return v;
  endfunction

  initial begin
    int k;
    logic r, s, pp, j, rt, c;
    logic [15:0] t;

    rst = 1'b1; stall = 1'b0; pcpp = 1'b0; jmp = 1'b0; ret = 1'b0;
    call = 1'b0; target = '0;
    m_pc = RESET_PC; m_ovf = 0; m_unf = 0; m_halt = 0;

    //             rst stl pp jmp ret cal target     pc       sp ovf unf hlt
    // reset and increment
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0003, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0004, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0, 0));
    // call/return nesting from 0x0010
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 16'h0100, 16'h0100, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 16'h0200, 16'h0200, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0101, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0011, 0, 0, 0, 0));
    // ret+JMP priority: stack top 0x0042, TARGET 0x0999
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0041, 16'h0041, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 16'h0500, 16'h0500, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0999, 16'h0042, 0, 0, 0, 0));
    // stall with Call held for 3 cycles
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 16'h0300, 16'h0300, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 16'h0700, 16'h0300, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 16'h0700, 16'h0300, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 16'h0700, 16'h0300, 1, 0, 0, 0));
    // halt, held across a stall, cleared by JMP
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0300, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0300, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0123, 16'h0300, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0123, 16'h0123, 1, 0, 0, 0));
    // underflow after reset, sticky across later cycles
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].pcpp, tbl[i].jmp, tbl[i].ret,
           tbl[i].call, tbl[i].target);
      check_outputs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].sp,
                    tbl[i].ovf, tbl[i].unf, tbl[i].halt);
    end

    // Overflow: 9 calls from 0x0020, then unwind in LIFO order.
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 0, 16'h0020);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 0, 0, 1, 16'h1000 + 16'(i * 16));
      check_outputs($sformatf("ovf_call%0d", i), 16'h1000 + 16'(i * 16),
                    (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 1'b0, 1'b0);
    end
    for (int i = 7; i >= 1; i--) begin
      step(0, 0, 0, 0, 1, 0, 16'h0000);
      check_outputs($sformatf("ovf_ret%0d", i), 16'h1000 + 16'((i - 1) * 16) + 16'd1,
                    4'(i), 1'b1, 1'b0, 1'b0);
    end
    step(0, 0, 0, 0, 1, 0, 16'h0000);
    check_outputs("ovf_ret0", 16'h0021, 4'd0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 0, 1, 0, 16'h0000);
    check_outputs("ovf_unf", RESET_PC, 4'd0, 1'b1, 1'b1, 1'b0);

    // Wrap: PC+1 at 0xFFFF and the return address pushed at 0xFFFF.
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 0, 16'hFFFF);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    check_outputs("wrap_inc", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 1, 0, 0, 16'hFFFF);
    step(0, 0, 1, 0, 0, 1, 16'h0050);
    check_outputs("wrap_call", 16'h0050, 4'd1, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 1, 0, 16'h0000);
    check_outputs("wrap_ret", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation, with STALL and ret also asserted.
    step(0, 0, 0, 0, 1, 0, 16'h0000);
    step(0, 0, 1, 0, 0, 1, 16'h0010);
    step(0, 0, 1, 0, 0, 1, 16'h0020);
    step(0, 0, 1, 0, 0, 1, 16'h0030);
    step(0, 0, 0, 0, 0, 0, 16'h0000);
    check_outputs("mid_pre", 16'h0030, 4'd3, 1'b0, 1'b1, 1'b1);
    step(1, 1, 0, 0, 1, 1, 16'h0777);
    check_outputs("mid_rst", RESET_PC, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 1, 0, 16'h0000);
    check_outputs("mid_after", RESET_PC, 4'd0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 7) == 0);
      k  = $urandom_range(0, 9);
      pp = 0; j = 0; rt = 0; c = 0;
      case (k)
        0:       ;
        1, 2:    pp = 1;
        3:       j = 1;
        4, 5:    begin rt = 1; j = 1'($urandom_range(0, 1)); end
        6, 7, 8: begin c = 1; pp = 1; end
        default: {pp, j, rt, c} = 4'($urandom_range(0, 15));
      endcase
      t = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      step(r, s, pp, j, rt, c, t);
      check_outputs($sformatf("rnd%0d", i), m_pc, 4'(m_stack.size()),
                    m_ovf, m_unf, m_halt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
